// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding control unit.
// A slot records the destination of an in-flight instruction.
package hazard_fwd_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_fwd_unit_cmp.sv
// Per-operand comparator: does a source register match the EX or MEM producer?
// x0 never matches, and an operand that is not read never matches.
module hazard_cmp
    import hazard_fwd_unit_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             use_rs,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wr,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wr,
    output logic             hit_ex,
    output logic             hit_mem
);

    assign hit_ex  = use_rs & ex_wr  & (ex_rd  != REG_X0) & (ex_rd  == rs);
    assign hit_mem = use_rs & mem_wr & (mem_rd != REG_X0) & (mem_rd == rs);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding selects, load-use stall and ID/EX bubble control, driven from a
// private 2-deep shadow of destination info that advances on negedge clk.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             flush,
    output logic             fwd_ex_1,
    output logic             fwd_mem_1,
    output logic             fwd_ex_2,
    output logic             fwd_mem_2,
    output logic             stall,
    output logic             clear,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    slot_t            ex_q, ex_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hit_ex_1, hit_mem_1, hit_ex_2, hit_mem_2;
    logic lu;

    hazard_cmp u_cmp_rs1 (
        .rs      (id_rs1),
        .use_rs  (id_use_rs1 & id_valid),
        .ex_rd   (ex_q.rd),
        .ex_wr   (ex_q.wr),
        .mem_rd  (mem_rd_q),
        .mem_wr  (mem_wr_q),
        .hit_ex  (hit_ex_1),
        .hit_mem (hit_mem_1)
    );

    hazard_cmp u_cmp_rs2 (
        .rs      (id_rs2),
        .use_rs  (id_use_rs2 & id_valid),
        .ex_rd   (ex_q.rd),
        .ex_wr   (ex_q.wr),
        .mem_rd  (mem_rd_q),
        .mem_wr  (mem_wr_q),
        .hit_ex  (hit_ex_2),
        .hit_mem (hit_mem_2)
    );

    // A flush squashes the consumer, so it overrides any load-use stall.
    assign lu        = ex_q.ld & (hit_ex_1 | hit_ex_2) & ~flush;
    assign stall     = lu;
    assign clear     = lu | flush | rst;
    assign fwd_ex_1  = hit_ex_1 & ~ex_q.ld;
    assign fwd_ex_2  = hit_ex_2 & ~ex_q.ld;
    assign fwd_mem_1 = hit_mem_1 & ~hit_ex_1;
    assign fwd_mem_2 = hit_mem_2 & ~hit_ex_2;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        mem_rd_d    = ex_q.rd;
        mem_wr_d    = ex_q.wr;
        ex_d        = SLOT_EMPTY;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!clear) begin
            ex_d.rd = id_rd;
            ex_d.wr = id_RegWrite & id_valid;
            ex_d.ld = id_MemRead & id_valid;
        end
        if (lu && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            ex_q        <= SLOT_EMPTY;
            mem_rd_q    <= REG_X0;
            mem_wr_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios followed by random traffic,
// all checked against a history-of-issued-instructions model.
module tb_hazard_fwd_unit;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             id_RegWrite, id_MemRead;
    logic             flush;
    logic             fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2;
    logic             stall, clear;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    // hist[0] = instruction now in EX, hist[1] = instruction now in MEM
    instr_t hist[2];
    int     m_stall_cnt;
    int     m_flush_cnt;
    bit     e_fwd_ex_1, e_fwd_mem_1, e_fwd_ex_2, e_fwd_mem_2, e_stall, e_clear;

    hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_RegWrite(id_RegWrite),
        .id_MemRead (id_MemRead),
        .flush      (flush),
        .fwd_ex_1   (fwd_ex_1),
        .fwd_mem_1  (fwd_mem_1),
        .fwd_ex_2   (fwd_ex_2),
        .fwd_mem_2  (fwd_mem_2),
        .stall      (stall),
        .clear      (clear),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Which in-flight instruction (0 = youngest) last wrote rs, or -1.
    function automatic int youngest(input int rs, input bit reads);
        if (!(reads && id_valid)) return -1;
        for (int k = 0; k < 2; k++) begin
            if (hist[k].wr && hist[k].rd != 0 && hist[k].rd == rs) return k;
        end
        return -1;
    endfunction

    function automatic void predict();
        int p1, p2;
        p1 = youngest(int'(id_rs1), id_use_rs1);
        p2 = youngest(int'(id_rs2), id_use_rs2);
        e_fwd_ex_1  = (p1 == 0) && !hist[0].ld;
        e_fwd_ex_2  = (p2 == 0) && !hist[0].ld;
        e_fwd_mem_1 = (p1 == 1);
        e_fwd_mem_2 = (p2 == 1);
        e_stall     = hist[0].ld && (p1 == 0 || p2 == 0) && !flush;
        e_clear     = e_stall || flush || rst;
    endfunction

    function automatic void advance();
        predict();
        if (rst) begin
            hist[0]     = '{0, 1'b0, 1'b0};
            hist[1]     = '{0, 1'b0, 1'b0};
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (e_stall) m_stall_cnt = (m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : CNT_MAX;
            if (flush)   m_flush_cnt = (m_flush_cnt < CNT_MAX) ? m_flush_cnt + 1 : CNT_MAX;
            hist[1] = hist[0];
            if (e_clear) hist[0] = '{0, 1'b0, 1'b0};
            else         hist[0] = '{int'(id_rd), id_RegWrite && id_valid, id_MemRead && id_valid};
        end
    endfunction

    // One cycle: model follows the negedge update, new inputs go in after the
    // posedge, and outputs are compared 1 time unit later.
    task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit wr, input bit ld, input bit fl, input bit r);
        @(negedge clk);
        advance();
        @(posedge clk);
        id_valid    = v;
        id_rs1      = 5'(rs1);
        id_rs2      = 5'(rs2);
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rd       = 5'(rd);
        id_RegWrite = wr;
        id_MemRead  = ld;
        flush       = fl;
        rst         = r;
        #1;
        predict();
        check_eq("fwd_ex_1", 32'(fwd_ex_1), 32'(e_fwd_ex_1));
        check_eq("fwd_mem_1", 32'(fwd_mem_1), 32'(e_fwd_mem_1));
        check_eq("fwd_ex_2", 32'(fwd_ex_2), 32'(e_fwd_ex_2));
        check_eq("fwd_mem_2", 32'(fwd_mem_2), 32'(e_fwd_mem_2));
        check_eq("stall", 32'(stall), 32'(e_stall));
        check_eq("clear", 32'(clear), 32'(e_clear));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
        if (fwd_ex_1 && fwd_mem_1) check_eq("fwd_onehot_1", 32'(1), 32'(0));
        if (fwd_ex_2 && fwd_mem_2) check_eq("fwd_onehot_2", 32'(1), 32'(0));
    endtask

    task automatic nop();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        hist[0]     = '{0, 1'b0, 1'b0};
        hist[1]     = '{0, 1'b0, 1'b0};
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0; id_rd = '0; id_RegWrite = 1'b0; id_MemRead = 1'b0; flush = 1'b0;

        // reset held across two edges
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_clear", 32'(clear), 32'(1));
        check_eq("rst_stall", 32'(stall), 32'(0));
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'(0));
        nop();

        // ALU -> ALU
        step(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5, 0, 1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("alu_fwd_ex_1", 32'(fwd_ex_1), 32'(1));
        check_eq("alu_fwd_mem_1", 32'(fwd_mem_1), 32'(0));
        step(1'b1, 0, 5, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("alu_fwd_mem_2", 32'(fwd_mem_2), 32'(1));
        check_eq("alu_fwd_ex_2", 32'(fwd_ex_2), 32'(0));

        // two producers of x7: youngest wins
        step(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("dbl_fwd_ex_1", 32'(fwd_ex_1), 32'(1));
        check_eq("dbl_fwd_mem_1", 32'(fwd_mem_1), 32'(0));

        // load-use: one stall cycle, then MEM forward
        step(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 0, 3, 1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_stall", 32'(stall), 32'(1));
        check_eq("lu_clear", 32'(clear), 32'(1));
        step(1'b1, 0, 3, 1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_after_stall", 32'(stall), 32'(0));
        check_eq("lu_fwd_mem_2", 32'(fwd_mem_2), 32'(1));
        check_eq("lu_stall_cnt", 32'(stall_cnt), 32'(1));

        // flush coincides with load-use: flush wins
        step(1'b1, 0, 0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4, 0, 1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("fl_stall", 32'(stall), 32'(0));
        check_eq("fl_clear", 32'(clear), 32'(1));
        nop();
        check_eq("fl_flush_cnt", 32'(flush_cnt), 32'(1));
        check_eq("fl_stall_cnt", 32'(stall_cnt), 32'(1));

        // x0 is never forwarded nor stalled on
        step(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("x0_stall", 32'(stall), 32'(0));
        check_eq("x0_fwd_ex_1", 32'(fwd_ex_1), 32'(0));
        step(1'b1, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("x0_fwd_mem_1", 32'(fwd_mem_1), 32'(0));

        // five more load-use events saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 0, 0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 2, 0, 1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 2, 0, 1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_eq("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));

        // reset mid-stream discards the load in flight
        step(1'b1, 0, 0, 1'b0, 1'b0, 9, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 9, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9, 9, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("mrst_stall_cnt", 32'(stall_cnt), 32'(0));
        check_eq("mrst_flush_cnt", 32'(flush_cnt), 32'(0));
        check_eq("mrst_stall", 32'(stall), 32'(0));
        check_eq("mrst_fwd_mem_1", 32'(fwd_mem_1), 32'(0));

        // random traffic over a small register window to provoke matches
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
